// File: rtl/mod_n_counter_prog.sv
// Programmable up/down modulo-M counter with load/clear, one-shot stop and a
// registered terminal-count pulse. Modulus 0 selects the parameter default N.
module mod_n_counter_prog #(
  parameter int W = 4,
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         done
);

  // N may equal 2**W, so only M-1 is ever held in W bits.
  localparam logic [W-1:0] N_M1 = W'(N - 1);

  logic [W-1:0] m_max_s;
  logic [W-1:0] q_d, q_q;
  logic         tc_d, tc_q;
  logic         done_d, done_q;

  // Next-state: clr > load > enabled step > hold; tc is a one-cycle pulse.
  always_comb begin
    m_max_s = (modulus == {W{1'b0}}) ? N_M1 : (modulus - {{(W-1){1'b0}}, 1'b1});
    q_d     = q_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (clr) begin
      q_d    = {W{1'b0}};
      done_d = 1'b0;
    end else if (load) begin
      q_d    = (load_val > m_max_s) ? m_max_s : load_val;
      done_d = 1'b0;
    end else if (en && !done_q) begin
      if (up) begin
        // Out-of-range q after a modulus reduction counts as terminal.
        if (q_q >= m_max_s) begin
          tc_d = 1'b1;
          if (oneshot) begin
            q_d    = m_max_s;
            done_d = 1'b1;
          end else begin
            q_d = {W{1'b0}};
          end
        end else begin
          q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        end
      end else begin
        if (q_q > m_max_s) begin
          q_d = m_max_s;
        end else if (q_q == {W{1'b0}}) begin
          tc_d = 1'b1;
          if (oneshot) begin
            q_d    = {W{1'b0}};
            done_d = 1'b1;
          end else begin
            q_d = m_max_s;
          end
        end else begin
          q_d = q_q - {{(W-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= {W{1'b0}};
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule
